step_profile_generator: RTL and testbench

- Motion-profile stage feeding the H-bridge driver's step and dir inputs.
- Accepts queued move commands over a valid/ready handshake: step count, direction, start velocity and signed acceleration.
- Runs a DDA phase accumulator, emitting clean step pulses with enforced direction setup time.
- Tracks absolute step position and reports completion or abort.

---
 rtl/step_profile_generator_if.sv | 28 ++
 rtl/step_profile_generator.sv | 203 ++++++++++++++++++++
 tb/tb_step_profile_generator.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_profile_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : step_profile_if
// Purpose  : Move-command valid/ready channel into the step profile generator.
// Revision : 1.0
// ============================================================================
interface step_profile_if #(
    parameter int MOVE_BITS = 32,
    parameter int RATE_BITS = 32
);
    logic                 move_valid;
    logic                 move_ready;
    logic                 move_dir;
    logic [MOVE_BITS-1:0] move_steps;
    logic [RATE_BITS-1:0] move_v0;
    logic [RATE_BITS-1:0] move_accel;

    modport master (
        output move_valid, move_dir, move_steps, move_v0, move_accel,
        input  move_ready
    );

    modport slave (
        input  move_valid, move_dir, move_steps, move_v0, move_accel,
        output move_ready
    );
endinterface
`default_nettype wire

// File: rtl/step_profile_generator.sv
`default_nettype none
// ============================================================================
// Module   : step_profile_generator
// Purpose  : DDA step/dir profile generator with direction setup and abort.
// Revision : 1.0
// ============================================================================
module step_profile_generator #(
    parameter int MOVE_BITS        = 32,
    parameter int RATE_BITS        = 32,
    parameter int POS_BITS         = 32,
    parameter int STEP_HIGH_CYCLES = 4,
    parameter int DIR_SETUP_CYCLES = 8
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    step_profile_if.slave                   s_move,
    input  wire logic                       i_abort,
    output logic                            o_step,
    output logic                            o_dir,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_aborted,
    output logic signed [POS_BITS-1:0]      o_position
);

    localparam int c_cnt_w = $clog2(2 * STEP_HIGH_CYCLES) + 1;
    localparam int c_set_w = $clog2(DIR_SETUP_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]   c_pulse_load = c_cnt_w'(2 * STEP_HIGH_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_high       = c_cnt_w'(STEP_HIGH_CYCLES);
    localparam logic [c_set_w-1:0]   c_setup_load = c_set_w'(DIR_SETUP_CYCLES - 1);
    localparam logic [RATE_BITS-1:0] c_vel_max    = '1;
    localparam logic [RATE_BITS-1:0] c_vel_min    = RATE_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [RATE_BITS-1:0]  r_acc;
    logic [RATE_BITS-1:0]  r_vel;
    logic [RATE_BITS-1:0]  r_accel;
    logic [MOVE_BITS-1:0]  r_steps_left;
    logic [c_set_w-1:0]    r_setup_cnt;
    logic [c_cnt_w-1:0]    r_pcnt;
    logic                  r_pending;
    logic                  r_abort_req;
    logic                  r_step;
    logic                  r_dir;
    logic                  r_done;
    logic                  r_aborted;
    logic [POS_BITS-1:0]   r_position;

    logic                  w_accept;
    logic                  w_rise;
    logic                  w_drain_exit;
    logic                  w_pulse_idle;
    logic [RATE_BITS:0]    w_sum;
    logic [RATE_BITS+1:0]  w_vel_sum;
    logic [RATE_BITS-1:0]  w_vel_sat;

    assign w_pulse_idle      = (r_pcnt == '0);
    assign w_sum             = {1'b0, r_acc} + {1'b0, r_vel};
    assign w_vel_sum         = {2'b00, r_vel} + {{2{r_accel[RATE_BITS-1]}}, r_accel};
    assign s_move.move_ready = (r_state == S_IDLE);

    // Two guard bits: the top one flags a negative sum, the next one overflow.
    always_comb begin
        w_vel_sat = w_vel_sum[RATE_BITS-1:0];
        if (w_vel_sum[RATE_BITS+1] || (w_vel_sum == '0)) begin
            w_vel_sat = c_vel_min;
        end else if (w_vel_sum[RATE_BITS]) begin
            w_vel_sat = c_vel_max;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rise       = 1'b0;
        w_drain_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_move.move_valid) begin
                    w_accept = 1'b1;
                    if (s_move.move_steps != '0) begin
                        w_state_next = (s_move.move_dir != r_dir) ? S_SETUP : S_RUN;
                    end
                end
            end
            S_SETUP: begin
                if (i_abort) begin
                    w_state_next = S_DRAIN;
                end else if (r_setup_cnt == '0) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_next = S_DRAIN;
                end else if (r_pending && w_pulse_idle) begin
                    w_rise = 1'b1;
                    if (r_steps_left == MOVE_BITS'(1)) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pulse_idle) begin
                    w_drain_exit = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_vel        <= '0;
            r_accel      <= '0;
            r_steps_left <= '0;
            r_setup_cnt  <= '0;
            r_pcnt       <= '0;
            r_pending    <= 1'b0;
            r_abort_req  <= 1'b0;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_position   <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;

            if (w_accept) begin
                r_acc        <= '0;
                r_vel        <= s_move.move_v0;
                r_accel      <= s_move.move_accel;
                r_steps_left <= s_move.move_steps;
                r_aborted    <= 1'b0;
                r_abort_req  <= 1'b0;
                if (s_move.move_steps == '0) begin
                    r_done <= 1'b1;
                end else if (s_move.move_dir != r_dir) begin
                    r_dir       <= s_move.move_dir;
                    r_setup_cnt <= c_setup_load;
                end
            end

            if ((r_state == S_SETUP) && (r_setup_cnt != '0)) begin
                r_setup_cnt <= r_setup_cnt - 1'b1;
            end

            if (r_state == S_RUN) begin
                r_acc <= w_sum[RATE_BITS-1:0];
                r_vel <= w_vel_sat;
            end

            // Single-entry pending: a carry arriving while one is queued is lost.
            if ((r_state != S_RUN) || i_abort || w_rise) begin
                r_pending <= 1'b0;
            end else if (w_sum[RATE_BITS]) begin
                r_pending <= 1'b1;
            end

            // Counter spans high plus low time; step stays high while it is above c_high.
            if (w_rise) begin
                r_step       <= 1'b1;
                r_pcnt       <= c_pulse_load;
                r_position   <= r_dir ? (r_position + POS_BITS'(1)) : (r_position - POS_BITS'(1));
                r_steps_left <= r_steps_left - 1'b1;
            end else if (!w_pulse_idle) begin
                r_pcnt <= r_pcnt - 1'b1;
                r_step <= (r_pcnt > c_high);
            end

            if ((r_state != S_IDLE) && i_abort) begin
                r_abort_req <= 1'b1;
            end

            if (w_drain_exit) begin
                r_done    <= 1'b1;
                r_aborted <= r_abort_req | i_abort;
            end
        end
    end

    assign o_step     = r_step;
    assign o_dir      = r_dir;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_aborted  = r_aborted;
    assign o_position = r_position;

endmodule
`default_nettype wire

// File: tb/tb_step_profile_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_profile_generator
// Purpose  : Directed table, corner sequences and random moves vs an event model.
// Revision : 1.0
// ============================================================================
module tb_step_profile_generator;
    localparam int     H     = 4;
    localparam int     DS    = 8;
    localparam int     LIMIT = 30000;
    localparam longint TWO32 = 64'sd4294967296;

    typedef struct {
        logic        dir;
        int          steps;
        logic [31:0] v0;
        logic [31:0] accel;
        int          pulses;
        logic [31:0] pos;
        bit          mono;
    } vec_t;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        abort_i = 1'b0;
    logic        step_o, dir_o, busy_o, done_o, aborted_o;
    logic [31:0] pos_o;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          obs_rise[$];
    int          obs_done[$];
    int          exp_rise[$];
    int          exp_done;
    logic        prev_step = 1'b0;
    logic        cur_dir;
    logic [31:0] exp_pos;

    step_profile_if #(.MOVE_BITS(32), .RATE_BITS(32)) mif ();

    step_profile_generator #(
        .MOVE_BITS(32), .RATE_BITS(32), .POS_BITS(32),
        .STEP_HIGH_CYCLES(H), .DIR_SETUP_CYCLES(DS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_move     (mif),
        .i_abort    (abort_i),
        .o_step     (step_o),
        .o_dir      (dir_o),
        .o_busy     (busy_o),
        .o_done     (done_o),
        .o_aborted  (aborted_o),
        .o_position (pos_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_o && !prev_step) obs_rise.push_back(cyc);
        if (done_o) obs_done.push_back(cyc);
        prev_step = step_o;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Event model: cycle at which each step goes high, derived from the
    // accumulator overflow times, the one-deep pending rule and high+low spacing.
    task automatic model_move(input int n_acc, input bit dir_chg, input longint v0,
                              input longint acl, input int steps, input int prev_s);
        longint acc, vel, sum;
        int     t, left, last_s;
        bit     pend, carry;
        exp_rise.delete();
        acc = 0; vel = v0; left = steps; last_s = prev_s; pend = 0;
        if (steps == 0) begin
            exp_done = n_acc + 1;
            return;
        end
        t = n_acc + 1 + (dir_chg ? DS : 0);
        while (left > 0 && t < n_acc + LIMIT) begin
            sum   = acc + vel;
            carry = (sum >= TWO32);
            acc   = carry ? sum - TWO32 : sum;
            vel   = vel + acl;
            if (vel < 1) vel = 1;
            else if (vel > TWO32 - 1) vel = TWO32 - 1;
            if (pend && (t >= last_s + 2 * H - 1)) begin
                last_s = t + 1;
                exp_rise.push_back(last_s);
                left--;
                pend = 0;
            end else if (carry) begin
                pend = 1;
            end
            t++;
        end
        exp_done = last_s + 2 * H;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!mif.move_ready && w < LIMIT) begin tick(); w++; end
        chk("ready_before_accept", mif.move_ready, 1);
    endtask

    task automatic run_move(input logic d, input int steps, input logic [31:0] v0,
                            input logic [31:0] acl, input int exp_pulses,
                            input logic [31:0] pos_req, input bit mono, output int first_gap);
        int   n, w, mism, viol, iv, pv;
        logic chg;
        wait_ready();
        chg = (steps != 0) && (d != cur_dir);
        mif.move_dir = d; mif.move_steps = steps; mif.move_v0 = v0;
        mif.move_accel = acl; mif.move_valid = 1'b1;
        n = cyc;
        obs_rise.delete(); obs_done.delete();
        tick();
        mif.move_valid = 1'b0;
        if (steps == 0) begin
            chk("zero_len_busy", busy_o, 0);
            chk("zero_len_done_next", done_o, 1);
        end else begin
            chk("busy_after_accept", busy_o, 1);
            chk("dir_after_accept", dir_o, d);
        end
        model_move(n, chg, longint'(v0), longint'($signed(acl)), steps, -1000);
        if (steps != 0) cur_dir = d;
        w = 0;
        while (obs_done.size() == 0 && w < LIMIT) begin tick(); w++; end
        chk("done_seen", obs_done.size(), 1);
        chk("pulse_count", obs_rise.size(), exp_pulses);
        chk("pulse_count_vs_model", obs_rise.size(), exp_rise.size());
        mism = 0;
        for (int i = 0; i < obs_rise.size() && i < exp_rise.size(); i++)
            if (obs_rise[i] != exp_rise[i]) mism++;
        chk("rise_time_mismatches", mism, 0);
        if (obs_done.size() > 0) chk("done_cycle", obs_done[0], exp_done);
        chk("position", pos_o, pos_req);
        chk("aborted_clear", aborted_o, 0);
        chk("busy_after_done", busy_o, 0);
        if (mono) begin
            // DDA quantisation allows a 1-clk wobble between neighbouring intervals.
            viol = 0;
            for (int i = 2; i < obs_rise.size(); i++) begin
                iv = obs_rise[i] - obs_rise[i-1];
                pv = obs_rise[i-1] - obs_rise[i-2];
                if (iv > pv + 1) viol++;
            end
            chk("interval_growth_violations", viol, 0);
            if (obs_rise.size() > 2)
                chk("interval_shrinks", (obs_rise[$] - obs_rise[$-1]) < (obs_rise[1] - obs_rise[0]), 1);
        end
        first_gap = (obs_rise.size() > 0) ? obs_rise[0] - (n + 1) : -1;
    endtask

    initial begin
        vec_t        tbl[5];
        int          gap, n, n1, n2, w, s3, d1;
        int          exp1[$];
        logic        d;
        int          st;
        logic [31:0] v0, acl;

        tbl[0] = '{1'b1, 4,   32'h2000_0000, 32'h0000_0000, 4,   32'd4,   1'b0};
        tbl[1] = '{1'b0, 2,   32'h2000_0000, 32'h0000_0000, 2,   32'd2,   1'b0};
        tbl[2] = '{1'b1, 100, 32'h0000_0001, 32'h0000_4000, 100, 32'd102, 1'b1};
        tbl[3] = '{1'b1, 1,   32'hFFFF_FFFF, 32'h8000_0001, 1,   32'd103, 1'b0};
        tbl[4] = '{1'b0, 0,   32'h2000_0000, 32'h0000_0000, 0,   32'd103, 1'b0};

        mif.move_valid = 1'b0; mif.move_dir = 1'b0; mif.move_steps = '0;
        mif.move_v0 = '0; mif.move_accel = '0;
        cur_dir = 1'b0; exp_pos = '0;

        repeat (3) tick();
        chk("rst_step", step_o, 0);
        chk("rst_busy", busy_o, 0);
        resetn = 1'b1;
        tick();
        chk("rst_dir", dir_o, 0);
        chk("rst_pos", pos_o, 0);
        chk("rst_ready", mif.move_ready, 1);
        chk("rst_done", done_o, 0);
        chk("rst_aborted", aborted_o, 0);

        for (int i = 0; i < 5; i++) begin
            run_move(tbl[i].dir, tbl[i].steps, tbl[i].v0, tbl[i].accel,
                     tbl[i].pulses, tbl[i].pos, tbl[i].mono, gap);
            if (i == 1) chk("dir_setup_gap_ok", gap >= DS, 1);
        end
        exp_pos = 32'd103;

        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_done", done_o, 0);

        // Abort two clocks into the third pulse.
        wait_ready();
        mif.move_dir = cur_dir; mif.move_steps = 10; mif.move_v0 = 32'h2000_0000;
        mif.move_accel = '0; mif.move_valid = 1'b1;
        obs_rise.delete(); obs_done.delete();
        tick();
        mif.move_valid = 1'b0;
        w = 0;
        while (obs_rise.size() < 3 && w < LIMIT) begin tick(); w++; end
        chk("abort_third_pulse_seen", obs_rise.size(), 3);
        s3 = (obs_rise.size() >= 3) ? obs_rise[2] : cyc;
        tick();
        tick(); abort_i = 1'b1;
        tick(); abort_i = 1'b0;
        chk("abort_full_high", step_o, 1);
        tick();
        chk("abort_pulse_fell", step_o, 0);
        w = 0;
        while (obs_done.size() == 0 && w < LIMIT) begin tick(); w++; end
        chk("abort_done_seen", obs_done.size(), 1);
        if (obs_done.size() > 0) chk("abort_done_cycle", obs_done[0], s3 + 2 * H);
        chk("abort_aborted", aborted_o, 1);
        exp_pos = exp_pos + (cur_dir ? 32'd3 : -32'd3);
        chk("abort_position", pos_o, exp_pos);
        repeat (20) tick();
        chk("abort_no_fourth", obs_rise.size(), 3);

        // Velocity driven into the floor: one pulse, then no runaway.
        wait_ready();
        mif.move_dir = cur_dir; mif.move_steps = 3; mif.move_v0 = 32'hFFFF_FFFF;
        mif.move_accel = 32'h8000_0001; mif.move_valid = 1'b1;
        n = cyc;
        obs_rise.delete(); obs_done.delete();
        tick();
        mif.move_valid = 1'b0;
        repeat (200) tick();
        chk("clamp_single_pulse", obs_rise.size(), 1);
        if (obs_rise.size() > 0) chk("clamp_rise_cycle", obs_rise[0], n + 4);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        w = 0;
        while (obs_done.size() == 0 && w < LIMIT) begin tick(); w++; end
        chk("clamp_done_seen", obs_done.size(), 1);
        chk("clamp_aborted", aborted_o, 1);
        exp_pos = exp_pos + (cur_dir ? 32'd1 : -32'd1);
        chk("clamp_position", pos_o, exp_pos);

        // Back-to-back: second command held valid through the first move.
        wait_ready();
        mif.move_dir = cur_dir; mif.move_steps = 2; mif.move_v0 = 32'h2000_0000;
        mif.move_accel = '0; mif.move_valid = 1'b1;
        n1 = cyc;
        obs_rise.delete(); obs_done.delete();
        tick();
        mif.move_steps = 1; mif.move_v0 = 32'hFFFF_FFFF;
        model_move(n1, 1'b0, 64'sh2000_0000, 0, 2, -1000);
        exp1 = exp_rise; d1 = exp_done;
        w = 0;
        while (!mif.move_ready && w < LIMIT) begin tick(); w++; end
        n2 = cyc;
        chk("b2b_accept_in_done_cycle", n2, d1);
        chk("b2b_done_at_accept", done_o, 1);
        tick();
        mif.move_valid = 1'b0;
        model_move(n2, 1'b0, 64'sh0_FFFF_FFFF, 0, 1, exp1[$]);
        w = 0;
        while (obs_done.size() < 2 && w < LIMIT) begin tick(); w++; end
        chk("b2b_rises", obs_rise.size(), 3);
        if (obs_rise.size() >= 3) begin
            chk("b2b_first_move_rise", obs_rise[1], exp1[1]);
            chk("b2b_second_rise", obs_rise[2], exp_rise[0]);
            chk("b2b_low_time_ok", (obs_rise[2] - obs_rise[1]) >= 2 * H, 1);
        end
        exp_pos = exp_pos + (cur_dir ? 32'd3 : -32'd3);
        chk("b2b_position", pos_o, exp_pos);

        for (int i = 0; i < 12; i++) begin
            d   = 1'($urandom_range(0, 1));
            st  = int'($urandom_range(1, 5));
            v0  = $urandom_range(32'h0100_0000, 32'h2000_0000);
            acl = $urandom_range(0, 32'h0001_0000);
            exp_pos = exp_pos + (d ? 32'(st) : -32'(st));
            run_move(d, st, v0, acl, st, exp_pos, 1'b0, gap);
        end

        // Reset in the middle of a high phase truncates the pulse.
        wait_ready();
        mif.move_dir = cur_dir; mif.move_steps = 5; mif.move_v0 = 32'h2000_0000;
        mif.move_accel = '0; mif.move_valid = 1'b1;
        obs_rise.delete();
        tick();
        mif.move_valid = 1'b0;
        w = 0;
        while (obs_rise.size() == 0 && w < LIMIT) begin tick(); w++; end
        tick();
        chk("midrst_step_high", step_o, 1);
        resetn = 1'b0;
        tick();
        chk("midrst_step", step_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_dir", dir_o, 0);
        chk("midrst_pos", pos_o, 0);
        chk("midrst_ready", mif.move_ready, 1);
        chk("midrst_aborted", aborted_o, 0);
        resetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
